// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the default bit period.
// The transmitter uses the same default so both ends agree out of the box.
package uart_pkg;

    localparam int CLKS_PER_BIT_DEF = 868;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_HIGH
    } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: serial line in, byte/valid/ready handshake and
// status pulses out.
interface uart_rx_if;
    import uart_pkg::*;

    logic       rx_serial;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_overrun;
    logic       rx_busy;

    modport master (
        output rx_serial, rx_ready,
        input  rx_data, rx_valid, rx_frame_err, rx_overrun, rx_busy
    );

    modport slave (
        input  rx_serial, rx_ready,
        output rx_data, rx_valid, rx_frame_err, rx_overrun, rx_busy
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; both flops reset to
// RST_VAL so an idle-high line does not look like an edge after reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, one-byte holding register,
// framing-error and overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input logic        clk,
    input logic        reset,
    uart_rx_if.slave   rx_if
);

    localparam int             CW       = $clog2(CLKS_PER_BIT);
    localparam int             HALF     = CLKS_PER_BIT / 2;
    localparam logic [CW-1:0]  CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  CNT_HALF = CW'(HALF - 1);

    logic          w_rxs;
    rx_state_t     r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic [7:0]    r_data;
    logic          r_valid;
    logic          r_frame_err;
    logic          r_overrun;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (rx_if.rx_serial),
        .o_q   (w_rxs)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            if (r_valid && rx_if.rx_ready)
                r_valid <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (!w_rxs) begin
                        r_state <= ST_START;
                        r_cnt   <= '0;
                    end
                end
                ST_START: begin
                    if (r_cnt == CNT_HALF) begin
                        if (!w_rxs) begin
                            r_state   <= ST_DATA;
                            r_cnt     <= '0;
                            r_bit_idx <= '0;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rxs, r_shift[7:1]};
                        if (r_bit_idx == 3'd7)
                            r_state <= ST_STOP;
                        else
                            r_bit_idx <= r_bit_idx + 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt <= '0;
                        if (w_rxs) begin
                            r_state <= ST_IDLE;
                            // A byte accepted this cycle frees the holder for the new one.
                            if (!r_valid || rx_if.rx_ready) begin
                                r_data  <= r_shift;
                                r_valid <= 1'b1;
                            end else begin
                                r_overrun <= 1'b1;
                            end
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= ST_WAIT_HIGH;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (w_rxs)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rx_if.rx_data      = r_data;
    assign rx_if.rx_valid     = r_valid;
    assign rx_if.rx_frame_err = r_frame_err;
    assign rx_if.rx_overrun   = r_overrun;
    assign rx_if.rx_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks/bit plus one frame at the default rate.
module tb_uart_rx;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;

    int n_cmp = 0;
    int n_mis = 0;

    uart_rx_if u_if16 ();
    uart_rx_if u_ifdef ();

    uart_rx #(.CLKS_PER_BIT(16)) u_dut16 (
        .clk   (clk),
        .reset (reset),
        .rx_if (u_if16.slave)
    );

    uart_rx u_dutdef (
        .clk   (clk),
        .reset (reset),
        .rx_if (u_ifdef.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    // Output monitors, sampled on the falling edge.
    int         n_ferr16 = 0, n_ovr16 = 0, rise16 = -1;
    int         n_ferrdef = 0, rise_def = -1;
    logic       pv16 = 1'b0, pvdef = 1'b0;
    logic [7:0] q16[$];
    logic [7:0] data_def = 8'h00;

    always @(negedge clk) begin
        if (u_if16.rx_frame_err) n_ferr16++;
        if (u_if16.rx_overrun)   n_ovr16++;
        if (u_if16.rx_valid && u_if16.rx_ready) q16.push_back(u_if16.rx_data);
        if (u_if16.rx_valid && !pv16) rise16 = cyc;
        pv16 = u_if16.rx_valid;
        if (u_ifdef.rx_frame_err) n_ferrdef++;
        if (u_ifdef.rx_valid && !pvdef) begin
            rise_def = cyc;
            data_def = u_ifdef.rx_data;
        end
        pvdef = u_ifdef.rx_valid;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit sel_def, input logic v);
        if (sel_def) u_ifdef.rx_serial = v;
        else         u_if16.rx_serial  = v;
    endtask

    // Bit-accurate 8N1 transmitter; t_start is the cycle the start bit went low.
    task automatic send_frame(input bit sel_def, input logic [7:0] b, input logic stop_v,
                              input int cpb, output int t_start);
        logic [9:0] f;
        f = {stop_v, b, 1'b0};
        t_start = cyc;
        for (int i = 0; i < 10; i++) begin
            drive(sel_def, f[i]);
            repeat (cpb) @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    int t0;
    int ferr_base, ovr_base;

    initial begin
        u_if16.rx_serial  = 1'b1;
        u_if16.rx_ready   = 1'b1;
        u_ifdef.rx_serial = 1'b1;
        u_ifdef.rx_ready  = 1'b1;
        reset = 1'b1;
        idle(5);
        chk("rst_data",  u_if16.rx_data, 8'h00);
        chk("rst_valid", u_if16.rx_valid, 1'b0);
        chk("rst_busy",  u_if16.rx_busy, 1'b0);
        chk("rst_ferr",  u_if16.rx_frame_err, 1'b0);
        chk("rst_ovr",   u_if16.rx_overrun, 1'b0);
        chk("rst_def_valid", u_ifdef.rx_valid, 1'b0);
        reset = 1'b0;
        idle(5);

        // Single frame: latency 3 (sync + detect) + HALF + 9*CPB = 155.
        send_frame(1'b0, 8'hA5, 1'b1, 16, t0);
        idle(3);
        chk("a5_latency", rise16 - t0, 155);
        chk("a5_count", q16.size(), 1);
        if (q16.size() > 0) chk("a5_data", q16[0], 8'hA5);
        chk("a5_ferr", n_ferr16, 0);
        chk("a5_ovr", n_ovr16, 0);
        chk("a5_valid_cleared", u_if16.rx_valid, 1'b0);
        q16.delete();

        // Start glitch shorter than half a bit is rejected.
        t0 = cyc;
        u_if16.rx_serial = 1'b0;
        idle(4);
        u_if16.rx_serial = 1'b1;
        chk("glitch_busy_mid", u_if16.rx_busy, 1'b1);
        idle(20);
        chk("glitch_busy_after", u_if16.rx_busy, 1'b0);
        chk("glitch_valid", u_if16.rx_valid, 1'b0);
        chk("glitch_ferr", n_ferr16, 0);
        chk("glitch_count", q16.size(), 0);

        // Framing error followed by a break, then a good frame.
        send_frame(1'b0, 8'h3C, 1'b0, 16, t0);
        idle(40);
        u_if16.rx_serial = 1'b1;
        idle(32);
        chk("ferr_pulses", n_ferr16, 1);
        chk("ferr_no_deliver", q16.size(), 0);
        chk("ferr_busy", u_if16.rx_busy, 1'b0);
        send_frame(1'b0, 8'h5A, 1'b1, 16, t0);
        idle(3);
        chk("after_ferr_count", q16.size(), 1);
        if (q16.size() > 0) chk("after_ferr_data", q16[0], 8'h5A);
        chk("after_ferr_pulses", n_ferr16, 1);
        q16.delete();

        // Overrun: consumer stalled across two frames.
        u_if16.rx_ready = 1'b0;
        ovr_base = n_ovr16;
        send_frame(1'b0, 8'h11, 1'b1, 16, t0);
        idle(4);
        send_frame(1'b0, 8'h22, 1'b1, 16, t0);
        idle(4);
        chk("ovr_data", u_if16.rx_data, 8'h11);
        chk("ovr_valid", u_if16.rx_valid, 1'b1);
        chk("ovr_pulses", n_ovr16 - ovr_base, 1);
        u_if16.rx_ready = 1'b1;
        idle(1);
        u_if16.rx_ready = 1'b0;
        idle(1);
        chk("ovr_valid_released", u_if16.rx_valid, 1'b0);
        u_if16.rx_ready = 1'b1;
        q16.delete();
        idle(4);

        // Back-to-back frames with no idle between stop and start.
        ferr_base = n_ferr16;
        ovr_base  = n_ovr16;
        send_frame(1'b0, 8'h00, 1'b1, 16, t0);
        send_frame(1'b0, 8'hFF, 1'b1, 16, t0);
        idle(3);
        chk("b2b_count", q16.size(), 2);
        if (q16.size() > 1) begin
            chk("b2b_first", q16[0], 8'h00);
            chk("b2b_second", q16[1], 8'hFF);
        end
        chk("b2b_ferr", n_ferr16 - ferr_base, 0);
        chk("b2b_ovr", n_ovr16 - ovr_base, 0);
        q16.delete();

        // Reset during bit 3, held until the line is idle again.
        fork
            send_frame(1'b0, 8'h96, 1'b1, 16, t0);
            begin
                repeat (16 * 4 + 6) @(negedge clk);
                reset = 1'b1;
                idle(4);
                chk("midrst_data", u_if16.rx_data, 8'h00);
                chk("midrst_valid", u_if16.rx_valid, 1'b0);
                chk("midrst_busy", u_if16.rx_busy, 1'b0);
                repeat (100) @(negedge clk);
                reset = 1'b0;
            end
        join
        idle(10);
        chk("postrst_busy", u_if16.rx_busy, 1'b0);
        chk("postrst_valid", u_if16.rx_valid, 1'b0);
        chk("postrst_ferr", n_ferr16 - ferr_base, 0);
        chk("postrst_count", q16.size(), 0);
        send_frame(1'b0, 8'h69, 1'b1, 16, t0);
        idle(3);
        chk("rst_then_count", q16.size(), 1);
        if (q16.size() > 0) chk("rst_then_data", q16[0], 8'h69);
        q16.delete();

        // Default bit period: latency 3 + 434 + 9*868 = 8249.
        send_frame(1'b1, 8'hA5, 1'b1, 868, t0);
        idle(3);
        chk("def_latency", rise_def - t0, 8249);
        chk("def_data", data_def, 8'hA5);
        chk("def_ferr", n_ferrdef, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
